// File: rtl/mask_share_gen.sv
// -----------------------------------------------------------------------------
// mask_share_gen
//
// Front end for a 2-share masked AND gadget. It splits two unmasked operand
// bits into Boolean shares with LFSR randomness, runs the external gadget, and
// recombines the gadget's output shares into the unmasked product.
//
// Flow: IDLE --start--> MASK (draw masks, register shares) --> RUN (gadget
// enabled, wait for done) --> UNMASK (one-cycle result strobe) --> IDLE.
// A watchdog in RUN returns to IDLE with a sticky error if the gadget never
// reports completion.
//
// Ports
//   clk          : rising-edge clock for all state
//   rst          : asynchronous, active-high reset
//   start        : one-cycle request, honoured only in IDLE
//   a, b         : unmasked operand bits, captured when start is accepted
//   seed_load    : load seed into the LFSR (a zero seed loads 16'h0001)
//   seed         : new LFSR state
//   ina, inb     : masked shares of a and b driven to the gadget
//   rin          : fresh refresh randomness for the gadget
//   AndEnable    : gadget enable, high only while in RUN
//   AndDone      : gadget completion flag
//   out          : gadget output shares
//   result       : unmasked product, held until the next UNMASK
//   result_valid : one-cycle strobe marking a new result
//   busy         : an operation is in flight
//   timeout_err  : sticky watchdog error, cleared by rst or an accepted start
//
// Only D = 2 is supported: the share construction and the recombination are
// written for exactly two shares.
// -----------------------------------------------------------------------------
module mask_share_gen #(
    parameter int          D            = 2,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   a,
    input  logic                   b,
    input  logic                   seed_load,
    input  logic [15:0]            seed,
    output logic [0:D-1]           ina,
    output logic [0:D-1]           inb,
    output logic [0:D*(D-1)/2-1]   rin,
    output logic                   AndEnable,
    input  logic                   AndDone,
    input  logic [0:D-1]           out,
    output logic                   result,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int RW = D * (D - 1) / 2;

    // The gadget's done flag from the previous operation may still be high
    // during the first RUN cycles; it is only trusted from this count onward.
    localparam logic [3:0] STALE_CYCLES  = 4'd2;
    // Last RUN cycle index before the watchdog fires (8 RUN cycles total).
    localparam logic [3:0] WATCHDOG_LAST = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MASK   = 2'd1,
        S_RUN    = 2'd2,
        S_UNMASK = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [15:0]       r_lfsr;
    logic              w_lfsr_fb;

    logic              r_a;
    logic              r_b;
    logic [0:D-1]      r_ina;
    logic [0:D-1]      r_inb;
    logic [0:RW-1]     r_rin;
    logic [3:0]        r_run_cnt;
    logic              r_result;
    logic              r_timeout_err;

    // Single-cycle control strobes decoded by the next-state logic.
    logic              w_accept_start;
    logic              w_load_shares;
    logic              w_accept_done;
    logic              w_timeout;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_accept_start = 1'b0;
        w_load_shares  = 1'b0;
        w_accept_done  = 1'b0;
        w_timeout      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept_start = 1'b1;
                    w_state_next   = S_MASK;
                end
            end

            S_MASK: begin
                w_load_shares = 1'b1;
                w_state_next  = S_RUN;
            end

            S_RUN: begin
                if (AndDone && (r_run_cnt >= STALE_CYCLES)) begin
                    w_accept_done = 1'b1;
                    w_state_next  = S_UNMASK;
                end else if (r_run_cnt == WATCHDOG_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end

            S_UNMASK: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // LFSR: 16-bit Fibonacci, taps 16,14,13,11, right-shifting. It advances
    // every cycle regardless of state so mask values are not tied to the
    // operation schedule. Tap n sits at bit (16 - n).
    // -------------------------------------------------------------------------
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED_DEFAULT;
        end else if (seed_load) begin
            // The all-zero state is a lock-up state for this LFSR.
            r_lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    // -------------------------------------------------------------------------
    // Operand capture and share generation
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= 1'b0;
            r_b <= 1'b0;
        end else if (w_accept_start) begin
            r_a <= a;
            r_b <= b;
        end
    end

    // Shares are written only on the MASK cycle, so they stay stable for the
    // whole RUN phase and are immune to a seed load mid-operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ina <= '0;
            r_inb <= '0;
            r_rin <= '0;
        end else if (w_load_shares) begin
            r_ina <= {r_a ^ r_lfsr[15], r_lfsr[15]};
            r_inb <= {r_b ^ r_lfsr[14], r_lfsr[14]};
            r_rin <= r_lfsr[13];
        end
    end

    // -------------------------------------------------------------------------
    // RUN cycle counter: 0 on the first RUN cycle, +1 per RUN cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_run_cnt <= r_run_cnt + 4'd1;
        end else begin
            r_run_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Result recombination and watchdog error
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 1'b0;
        end else if (w_accept_done) begin
            r_result <= out[0] ^ out[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if (w_accept_start) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Status strobes are decoded from the state register, so reset
    // clears them asynchronously along with the state.
    // -------------------------------------------------------------------------
    assign ina          = r_ina;
    assign inb          = r_inb;
    assign rin          = r_rin;
    assign AndEnable    = (r_state == S_RUN);
    assign result_valid = (r_state == S_UNMASK);
    assign busy         = (r_state != S_IDLE);
    assign result       = r_result;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_mask_share_gen.sv
// -----------------------------------------------------------------------------
// tb_mask_share_gen
//
// Directed-plus-random bench for mask_share_gen. A registered 2-share ISW AND
// gadget model answers the DUT; expected shares come from an LFSR reference
// that advances a stored base value by the number of clock edges elapsed.
// Latency is counted in rising edges after the accepting edge: result_valid
// must be seen high by edge N+6.
// -----------------------------------------------------------------------------
module tb_mask_share_gen;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
    localparam int          LFSR_TAPS[4] = '{16, 14, 13, 11};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        a;
    logic        b;
    logic        seed_load;
    logic [15:0] seed;
    logic [0:1]  ina;
    logic [0:1]  inb;
    logic [0:0]  rin;
    logic        AndEnable;
    logic        AndDone;
    logic [0:1]  out;
    logic        result;
    logic        result_valid;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mask_share_gen #(
        .D            (2),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a            (a),
        .b            (b),
        .seed_load    (seed_load),
        .seed         (seed),
        .ina          (ina),
        .inb          (inb),
        .rin          (rin),
        .AndEnable    (AndEnable),
        .AndDone      (AndDone),
        .out          (out),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // -------------------------------------------------------------------------
    // Gadget model: completes after 3 enabled edges. Its done flag is left
    // high between runs and is cleared on enabled edge g_clear_at, so it is
    // stale during the first RUN cycle(s) of the next operation.
    // -------------------------------------------------------------------------
    int         g_ecnt     = 0;
    int         g_clear_at = 1;
    bit         g_done_en  = 1'b1;
    logic       g_done     = 1'b0;
    logic [0:1] g_out      = 2'b00;

    always @(posedge clk) begin
        if (!AndEnable) begin
            g_ecnt <= 0;
        end else begin
            g_ecnt <= g_ecnt + 1;
            if (g_ecnt + 1 == g_clear_at) g_done <= 1'b0;
            if (g_ecnt + 1 == 3 && g_done_en) begin
                g_done   <= 1'b1;
                g_out[0] <= (ina[0] & inb[0]) ^ rin[0];
                g_out[1] <= (ina[1] & inb[1]) ^ ((rin[0] ^ (ina[0] & inb[1])) ^ (ina[1] & inb[0]));
            end
        end
    end

    assign AndDone = g_done;
    assign out     = g_out;

    // -------------------------------------------------------------------------
    // LFSR reference: value = base advanced by (edges since base was taken).
    // -------------------------------------------------------------------------
    int          edge_no  = 0;
    logic [15:0] ref_base = SEED_DEFAULT;
    int          ref_edge = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] x;
        logic        fb;
        int          idx;
        x = v;
        for (int s = 0; s < n; s++) begin
            fb = 1'b0;
            foreach (LFSR_TAPS[k]) begin
                idx = 16 - LFSR_TAPS[k];
                fb  = fb ^ x[idx[3:0]];
            end
            x = {fb, x[15:1]};
        end
        return x;
    endfunction

    task automatic rebase();
        ref_base = lfsr_adv(ref_base, edge_no - ref_edge);
        ref_edge = edge_no;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [4:0] seen0 = 5'b0;
    logic [4:0] seen1 = 5'b0;
    logic       last_result = 1'b0;

    task automatic load_seed(input logic [15:0] v);
        @(negedge clk);
        seed_load = 1'b1;
        seed      = v;
        @(negedge clk);
        seed_load = 1'b0;
        ref_base  = (v == 16'h0000) ? 16'h0001 : v;
        ref_edge  = edge_no;
    endtask

    // One complete operation with optional disturbances in RUN cycle 1.
    task automatic run_op(input logic ia, input logic ib, input bit expect_timeout,
                          input bit poke_start, input bit poke_seed, input logic [15:0] poke_val);
        logic [15:0] l;
        logic [0:1]  e_ina;
        logic [0:1]  e_inb;
        logic        e_rin;
        logic        exp_res;
        int          rv_cnt;
        int          rv_at;
        int          en_cnt;
        bit          done;

        exp_res = ia & ib;
        @(negedge clk);
        check("idle_before_start", 32'(busy), 32'd0);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        rebase();
        l     = ref_base;
        e_ina = {ia ^ l[15], l[15]};
        e_inb = {ib ^ l[14], l[14]};
        e_rin = l[13];
        check("busy_after_accept", 32'(busy), 32'd1);
        check("timeout_cleared_on_start", 32'(timeout_err), 32'd0);

        rv_cnt = 0;
        rv_at  = 0;
        en_cnt = 0;
        done   = 1'b0;
        for (int i = 1; i <= 24 && !done; i++) begin
            @(negedge clk);
            if (poke_start && i == 3) begin
                start = 1'b1;
                a     = ~ia;
                b     = ~ib;
            end
            if (poke_start && i == 4) start = 1'b0;
            if (poke_seed && i == 3) begin
                seed_load = 1'b1;
                seed      = poke_val;
            end
            if (poke_seed && i == 4) begin
                seed_load = 1'b0;
                ref_base  = (poke_val == 16'h0000) ? 16'h0001 : poke_val;
                ref_edge  = edge_no;
            end
            if (AndEnable) begin
                en_cnt++;
                check("ina_held_in_run", 32'(ina), 32'(e_ina));
                check("inb_held_in_run", 32'(inb), 32'(e_inb));
                check("rin_held_in_run", 32'(rin), 32'(e_rin));
            end
            if (result_valid) begin
                rv_cnt++;
                rv_at = i;
                check("result_at_valid", 32'(result), 32'(exp_res));
            end
            if (!busy) done = 1'b1;
        end
        check("op_completed", 32'(done), 32'd1);

        if (expect_timeout) begin
            check("timeout_no_valid", 32'(rv_cnt), 32'd0);
            check("timeout_err_set", 32'(timeout_err), 32'd1);
            check("timeout_run_cycles", 32'(en_cnt), 32'd8);
            check("timeout_result_held", 32'(result), 32'(last_result));
        end else begin
            check("valid_once", 32'(rv_cnt), 32'd1);
            check("latency", 32'(rv_at), 32'd6);
            check("run_cycles", 32'(en_cnt), 32'd4);
            check("result_held", 32'(result), 32'(exp_res));
            check("no_timeout", 32'(timeout_err), 32'd0);
            last_result = exp_res;
        end
        check("ina_unmasks_to_a", 32'(ina[0] ^ ina[1]), 32'(ia));
        check("inb_unmasks_to_b", 32'(inb[0] ^ inb[1]), 32'(ib));
        check("ina_after_op", 32'(ina), 32'(e_ina));

        seen1 = seen1 | {ina[0], ina[1], inb[0], inb[1], rin[0]};
        seen0 = seen0 | ~{ina[0], ina[1], inb[0], inb[1], rin[0]};

        @(negedge clk);
        check("idle_after_op", 32'(busy), 32'd0);
        check("no_extra_valid", 32'(result_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [15:0] seeds[3];
        rst       = 1'b1;
        start     = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0000;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ina", 32'(ina), 32'd0);
        check("rst_inb", 32'(inb), 32'd0);
        check("rst_rin", 32'(rin), 32'd0);
        check("rst_and_enable", 32'(AndEnable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        ref_base = SEED_DEFAULT;
        ref_edge = edge_no;

        // All operand pairs under three seeds (default, then two loaded).
        seeds = '{SEED_DEFAULT, 16'h1234, 16'hBEEF};
        for (int s = 0; s < 3; s++) begin
            if (s != 0) load_seed(seeds[s]);
            for (int p = 0; p < 4; p++) begin
                run_op(p[1], p[0], 1'b0, 1'b0, 1'b0, 16'h0);
            end
        end

        // Stale done held for RUN cycles 0 and 1; stale out would give 1.
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        g_clear_at = 2;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        g_clear_at = 1;

        // Gadget never completes: watchdog, then the next start clears it.
        g_done_en = 1'b0;
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        g_done_en = 1'b1;
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Reset asserted in RUN cycle 1 with a previous result of 1.
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        start = 1'b1;
        a     = 1'b1;
        b     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("enabled_before_abort", 32'(AndEnable), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_and_enable", 32'(AndEnable), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_result_valid", 32'(result_valid), 32'd0);
        check("abort_timeout_err", 32'(timeout_err), 32'd0);
        check("abort_ina", 32'(ina), 32'd0);
        check("abort_inb", 32'(inb), 32'd0);
        check("abort_rin", 32'(rin), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        ref_base    = SEED_DEFAULT;
        ref_edge    = edge_no;
        last_result = 1'b0;
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        // Zero seed loads 0001; a start during RUN is ignored; a seed load
        // during RUN leaves the latched shares alone.
        load_seed(16'h0000);
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A);

        // Random operations; every share bit must take both values.
        for (int n = 0; n < 256; n++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 16'h0);
        end
        check("share_bits_seen_0", 32'(seen0), 32'h1f);
        check("share_bits_seen_1", 32'(seen1), 32'h1f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mask_share_gen.md
MASK_SHARE_GEN -- requirements
Module: mask_share_gen

Interface
REQ-001 Parameter: D, default 2, number of shares; only D=2 is supported.
REQ-002 Parameter: SEED_DEFAULT, default 16'hACE1, LFSR value after reset.
REQ-003 Single clock domain; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to process one unmasked bit pair.
REQ-007 a, b  in  1 each  unmasked operand bits, sampled when start is accepted.
REQ-008 seed_load, seed  in  1, 16  load a new LFSR state.
REQ-009 ina, inb  out  [0:D-1]  masked shares driven to the AND gadget.
REQ-010 rin  out  [0:D*(D-1)/2-1]  fresh refresh randomness driven to the AND gadget.
REQ-011 AndEnable  out  1  enable to the AND gadget.
REQ-012 AndDone  in  1  done flag from the AND gadget.
REQ-013 out  in  [0:D-1]  output shares returned by the AND gadget.
REQ-014 result, result_valid  out  1, 1  unmasked product and its one-cycle strobe.
REQ-015 busy, timeout_err  out  1, 1  operation in flight; sticky watchdog error.

Function
REQ-016 LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts one step every cycle in every state.
REQ-017 seed_load has priority over shifting; seed==0 loads 16'h0001; a load during an operation does not alter shares that are already latched.
REQ-018 FSM states: IDLE, MASK, RUN, UNMASK.
REQ-019 IDLE: start=1 latches a and b, sets busy=1, and goes to MASK; start is ignored in every other state.
REQ-020 MASK (1 cycle): with m0=lfsr[15], m1=lfsr[14], r=lfsr[13], register ina={a^m0, m0}, inb={b^m1, m1}, rin={r}; then go to RUN.
REQ-021 ina, inb and rin are held constant from MASK exit until the next MASK; they are never recomputed while RUN is active.
REQ-022 RUN: AndEnable=1, and an internal run counter starts at 0 on entry and increments every cycle.
REQ-023 RUN: AndDone is ignored while run counter <2 (the gadget's stale done flag); AndDone=1 with counter >=2 captures out[0]^out[1] into result and moves to UNMASK.
REQ-024 RUN watchdog: if the counter reaches 8 without an accepted AndDone, set timeout_err=1 and go to IDLE with no result_valid.
REQ-025 UNMASK (1 cycle): AndEnable=0, result_valid=1, then go to IDLE with busy=0.
REQ-026 Latency: start accepted at edge N gives result_valid high in cycle N+6 with a gadget that completes in 3 enabled cycles.
REQ-027 result holds its value until the next UNMASK; result_valid is high for exactly one cycle per operation.
REQ-028 timeout_err clears only on rst or on the next accepted start.
REQ-029 AndEnable is high only in RUN and is never high for two non-consecutive runs without an intervening MASK.

Reset
REQ-030 On rst, asynchronously force: state=IDLE, AndEnable=0, busy=0, result=0, result_valid=0, timeout_err=0, ina=inb=0, rin=0, lfsr=SEED_DEFAULT.
REQ-031 rst asserted in any state, including mid-RUN, aborts the operation with no result_valid.
REQ-032 After rst, the first start is accepted normally.

Verification
REQ-033 Connect a model of the 2-share AND gadget and sweep a,b over 00, 01, 10, 11 with 3 different seeds -> result = a&b each time, result_valid once, latency 6.
REQ-034 Two back-to-back operations where the gadget AndDone is still 1 from the previous run -> the stale done is not accepted in RUN cycles 0 and 1, and the result is correct.
REQ-035 Hold AndDone=0 -> timeout_err=1 after 8 RUN cycles, state returns to IDLE, no result_valid; the next start clears timeout_err.
REQ-036 Assert rst in RUN cycle 1 -> AndEnable=0 and all outputs 0 asynchronously; a subsequent a=1, b=1 operation gives result=1.
REQ-037 seed_load with seed=0 -> lfsr=16'h0001 and never stalls at zero; start asserted in RUN is ignored, so there is exactly one result.
REQ-038 Share check: in every operation ina[0]^ina[1]=a and inb[0]^inb[1]=b; over 256 operations each share bit takes both values.
